// File: rtl/xor_cipher_ctrl_if.sv
// Handshake and datapath bundle between the pin side, the controller and the key assembler.
// The master side drives pins and assembler feedback; the slave side is the controller.
interface xor_cipher_ctrl_if #(
  parameter int unsigned KEY_SIZE = 4,
  parameter int unsigned MSG_SIZE = 8
);
  logic                start;
  logic                reuse_key;
  logic [KEY_SIZE-1:0] key;
  logic                key_valid;
  logic                key_ready;
  logic                en;
  logic                assemble;
  logic [KEY_SIZE-1:0] asm_key;
  logic [MSG_SIZE-1:0] key_assembled;
  logic                assembled;
  logic [MSG_SIZE-1:0] msg;
  logic                msg_valid;
  logic                msg_ready;
  logic [MSG_SIZE-1:0] cipher;
  logic                valid;
  logic                out_ready;
  logic                busy;
  logic                key_loaded;
  logic                error;

  modport master (
    output start, reuse_key, key, key_valid, key_assembled, assembled, msg, msg_valid,
           out_ready,
    input  key_ready, en, assemble, asm_key, msg_ready, cipher, valid, busy, key_loaded, error
  );

  modport slave (
    input  start, reuse_key, key, key_valid, key_assembled, assembled, msg, msg_valid,
           out_ready,
    output key_ready, en, assemble, asm_key, msg_ready, cipher, valid, busy, key_loaded, error
  );
endinterface

// File: rtl/xor_cipher_ctrl.sv
// Sequencer for the key assembler and the XOR stage: loads key beats, latches the assembled
// key, then XORs one message word per transaction behind a valid/ready output.
module xor_cipher_ctrl #(
  parameter int unsigned KEY_SIZE = 4,
  parameter int unsigned MSG_SIZE = 8,
  parameter int unsigned TIMEOUT  = 15
) (
  input logic              clk,
  input logic              rst_n,
  xor_cipher_ctrl_if.slave bus
);
  localparam int unsigned N    = MSG_SIZE / KEY_SIZE;
  localparam int unsigned CntW = $clog2(N + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StLoadKey, StWaitAsm, StWaitMsg, StOutput} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     beat_q, beat_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic [MSG_SIZE-1:0] key_q, key_d;
  logic [MSG_SIZE-1:0] cipher_q, cipher_d;
  logic                loaded_q, loaded_d;
  logic                valid_q, valid_d;
  logic                error_q, error_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      beat_q   <= '0;
      tmo_q    <= '0;
      key_q    <= '0;
      cipher_q <= '0;
      loaded_q <= 1'b0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      tmo_q    <= tmo_d;
      key_q    <= key_d;
      cipher_q <= cipher_d;
      loaded_q <= loaded_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    tmo_d         = tmo_q;
    key_d         = key_q;
    cipher_d      = cipher_q;
    loaded_d      = loaded_q;
    valid_d       = valid_q;
    error_d       = 1'b0;
    bus.key_ready = 1'b0;
    bus.en        = 1'b0;
    bus.assemble  = 1'b0;
    bus.asm_key   = '0;
    bus.msg_ready = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.reuse_key && loaded_q) begin
            state_d = StWaitMsg;
          end else begin
            state_d  = StLoadKey;
            loaded_d = 1'b0;
            beat_d   = '0;
          end
        end
      end
      StLoadKey: begin
        // Assembler only advances on cycles carrying a real beat.
        bus.key_ready = 1'b1;
        bus.en        = bus.key_valid;
        bus.assemble  = bus.key_valid;
        bus.asm_key   = bus.key;
        if (bus.key_valid) begin
          beat_d = beat_q + CntW'(1);
          if (beat_q == CntW'(N - 1)) begin
            state_d = StWaitAsm;
            tmo_d   = '0;
          end
        end
      end
      StWaitAsm: begin
        bus.en       = 1'b1;
        bus.assemble = 1'b1;
        if (bus.assembled) begin
          key_d    = bus.key_assembled;
          loaded_d = 1'b1;
          state_d  = StWaitMsg;
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          error_d  = 1'b1;
          loaded_d = 1'b0;
          state_d  = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StWaitMsg: begin
        // en low here lets the assembler self-clear.
        bus.msg_ready = 1'b1;
        if (bus.msg_valid) begin
          cipher_d = bus.msg ^ key_q;
          valid_d  = 1'b1;
          state_d  = StOutput;
        end
      end
      StOutput: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.cipher     = cipher_q;
  assign bus.valid      = valid_q;
  assign bus.key_loaded = loaded_q;
  assign bus.error      = error_q;
endmodule
